fp_div: RTL and testbench
=========================

Name: fp_div

Overview:
- Iterative floating-point divider; the inverse operation of the combinational multiplier in the Processing/FloatingPoint datapath.
- Computes OUT = A / B using restoring mantissa division, one quotient bit per clock.
- Uses the same sign/8-bit-exponent/MANTISSA format, flush-to-zero policy, truncation rounding and canonical NaN as the multiplier.
- Valid/ready on both sides, so it can sit behind the processing-unit issue logic and stall it.

Parameters:
- MANTISSA, 8, fraction bits (exponent fixed at 8, bias 127, WIDTH = MANTISSA+9)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset; single clock domain
- in_valid  in  1  operands present
- in_ready  out  1  divider accepts operands (high only in IDLE)
- A  in  WIDTH  dividend
- B  in  WIDTH  divisor
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- OUT  out  WIDTH  quotient
- div_by_zero  out  1  qualified by out_valid; finite nonzero A divided by zero B

Behaviour:
- Reset: state=IDLE, out_valid=0, OUT=0, div_by_zero=0, in_ready=1 from the first cycle after reset.
  - Reset asserted mid-operation aborts the operation; no result is emitted.
- Accept: in_valid && in_ready on a rising edge latches A and B. in_ready is combinational (state==IDLE).
- Classification (exponent 0 is zero, flush-to-zero; exponent 255 with f==0 is inf; exponent 255 with f!=0 is NaN). Priority order:
  - NaN if A NaN, B NaN, 0/0 or inf/inf. Result 17'h1FF80 pattern: sign 1, exp all ones, fraction MSB 1.
  - Signed inf if A inf (B finite), or B zero (A finite nonzero). The B-zero case also sets div_by_zero=1.
  - Signed zero if A zero, or B inf.
  - Any special case goes IDLE->DONE; out_valid rises on the next edge after accept.
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
  - DIVIDE: R={1,fa}, D={1,fb}, both MANTISSA+2 bits wide. For MANTISSA+2 cycles: if R>=D then q bit=1 and R=R-D; then R<<=1. Quotient bits fill q[MANTISSA+1:0] MSB first, tracked by a counter that counts down to 0.
  - NORM: e = Ae - Be + 127, computed signed 10-bit.
    - If q[MANTISSA+1]: frac = q[MANTISSA:1].
    - Else: frac = q[MANTISSA-1:0] and e = e-1.
    - e<=0 gives signed zero (flush).
    - e>=255 gives signed inf.
    - Otherwise OUT = {sA^sB, e[7:0], frac}.
    - Remainder is discarded: truncate toward zero.
  - Normal-path latency: out_valid rises exactly MANTISSA+3 edges after the accept edge.
- DONE: out_valid=1. OUT and div_by_zero are held stable until out_valid && out_ready. That edge returns to IDLE and clears out_valid.
  - No overlap: the next accept can occur no earlier than the cycle after the handshake edge.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Decomposition:
- Package fp_pkg holds:
  - EXPONENT=8, BIAS=127, MAX_EXPONENT
  - canonical NaN constant
  - state enum
  - unpack/classify functions (is_zero/is_inf/is_nan), shared with the multiplier.
- One sub-module, fp_div_mant_core: the restoring divider (R, D, q, counter, start/done).
- fp_div owns handshake, classification, exponent and normalization.

Test Plan (MANTISSA=8):
- A=0x08180 (6.0), B=0x08080 (3.0) -> OUT=0x08000 (2.0), div_by_zero=0, out_valid exactly 11 edges after accept.
- A=0x07F00 (1.0), B=0x08080 (3.0) -> OUT=0x07D55 (normalize path, truncated). Also A=0x18180 (-6.0), B=0x08000 -> OUT=0x18080.
- Specials: 0x07F00/0x00000 -> 0x0FF00 with div_by_zero=1; 0x00000/0x00000 -> 0x1FF80; 0x0FF00/0x0FF00 -> 0x1FF80; 0x07F00/0x0FF00 -> 0x00000. Each has out_valid one edge after accept.
- Range: 0x00100/0x08000 -> 0x00000 (underflow flush); 0x0FE00/0x07E00 -> 0x0FF00 (overflow to inf, div_by_zero=0).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> OUT stable, in_ready=0, in_valid pulses ignored. Release -> IDLE, in_ready=1 on the next cycle.
- Assert reset 4 cycles into DIVIDE -> out_valid stays 0, in_ready=1 after reset. A new op (6.0/3.0) then completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point format constants, FSM states and operand classifiers
package fp_pkg;

    localparam int EXPONENT = 8;
    localparam int BIAS = 127;
    localparam logic [EXPONENT-1:0] MAX_EXPONENT = 8'hFF;
    // Canonical NaN: sign set, exponent all ones, only the fraction MSB set
    localparam logic NAN_SIGN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_NORM,
        ST_DONE
    } state_e;

    function automatic logic is_zero(input logic [EXPONENT-1:0] exp_f);
        return exp_f == '0;
    endfunction

    function automatic logic is_inf(input logic [EXPONENT-1:0] exp_f, input logic frac_nz);
        return (exp_f == MAX_EXPONENT) && !frac_nz;
    endfunction

    function automatic logic is_nan(input logic [EXPONENT-1:0] exp_f, input logic frac_nz);
        return (exp_f == MAX_EXPONENT) && frac_nz;
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// rtl/fp_div_mant_core.sv - restoring mantissa divider, one quotient bit per clock
module fp_div_mant_core #(
    parameter int MANTISSA = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [MANTISSA-1:0] fa_i,
    input  logic [MANTISSA-1:0] fb_i,
    output logic [MANTISSA+1:0] q_o,
    output logic                done_o
);

    localparam int QW = MANTISSA + 2;
    localparam int CW = $clog2(QW);

    logic [QW-1:0] r_q, d_q, q_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          ge;
    logic [QW-1:0] diff;

    assign ge   = r_q >= d_q;
    assign diff = ge ? (r_q - d_q) : r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            d_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            r_q    <= {2'b01, fa_i};
            d_q    <= {2'b01, fb_i};
            q_q    <= '0;
            cnt_q  <= CW'(QW - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            // Partial remainder stays below D, so the left shift never loses a set bit
            r_q <= diff << 1;
            q_q <= {q_q[QW-2:0], ge};
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign q_o    = q_q;
    assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/fp_div.sv
// rtl/fp_div.sv - iterative floating-point divider with valid/ready handshake
module fp_div
    import fp_pkg::*;
#(
    parameter int MANTISSA = 8,
    localparam int WIDTH = MANTISSA + EXPONENT + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] CANON_NAN = {NAN_SIGN, MAX_EXPONENT, 1'b1, {(MANTISSA-1){1'b0}}};

    logic                sa, sb, res_sign;
    logic [EXPONENT-1:0] ea, eb;
    logic [MANTISSA-1:0] fa, fb;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic special, spec_dbz, accept;
    logic [WIDTH-1:0] spec_val;

    state_e              state_q;
    logic [EXPONENT-1:0] ea_q, eb_q;
    logic                sign_q, out_valid_q, dbz_q;
    logic [WIDTH-1:0]    out_q;

    logic [MANTISSA+1:0] quot;
    logic                core_done;
    logic signed [9:0]   e_raw, e_norm;
    logic [MANTISSA-1:0] frac;
    logic [WIDTH-1:0]    norm_val;

    assign sa = A[WIDTH-1];
    assign ea = A[WIDTH-2 -: EXPONENT];
    assign fa = A[MANTISSA-1:0];
    assign sb = B[WIDTH-1];
    assign eb = B[WIDTH-2 -: EXPONENT];
    assign fb = B[MANTISSA-1:0];
    assign res_sign = sa ^ sb;

    assign a_zero = is_zero(ea);
    assign a_inf  = is_inf(ea, |fa);
    assign a_nan  = is_nan(ea, |fa);
    assign b_zero = is_zero(eb);
    assign b_inf  = is_inf(eb, |fb);
    assign b_nan  = is_nan(eb, |fb);

    assign special  = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        spec_val = '0;
        spec_dbz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val = CANON_NAN;
        end else if (a_inf || (b_zero && !a_zero)) begin
            spec_val = {res_sign, MAX_EXPONENT, {MANTISSA{1'b0}}};
            spec_dbz = b_zero && !a_inf;
        end else begin
            spec_val = {res_sign, {(WIDTH-1){1'b0}}};
        end
    end

    fp_div_mant_core #(.MANTISSA(MANTISSA)) u_core (
        .clk    (clk),
        .reset  (reset),
        .start_i(accept && !special),
        .fa_i   (fa),
        .fb_i   (fb),
        .q_o    (quot),
        .done_o (core_done)
    );

    // Quotient of two [1,2) mantissas lies in (0.5,2); a clear MSB costs one exponent step
    always_comb begin
        e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(10'(BIAS));
        if (quot[MANTISSA+1]) begin
            frac   = quot[MANTISSA:1];
            e_norm = e_raw;
        end else begin
            frac   = quot[MANTISSA-1:0];
            e_norm = e_raw - 10'sd1;
        end
        if (e_norm <= 10'sd0) begin
            norm_val = {sign_q, {(WIDTH-1){1'b0}}};
        end else if (e_norm >= 10'sd255) begin
            norm_val = {sign_q, MAX_EXPONENT, {MANTISSA{1'b0}}};
        end else begin
            norm_val = {sign_q, e_norm[EXPONENT-1:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ea_q        <= '0;
            eb_q        <= '0;
            sign_q      <= 1'b0;
            out_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    ea_q   <= ea;
                    eb_q   <= eb;
                    sign_q <= res_sign;
                    if (special) begin
                        out_q   <= spec_val;
                        dbz_q   <= spec_dbz;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: if (core_done) state_q <= ST_NORM;
                ST_NORM: begin
                    out_q       <= norm_val;
                    dbz_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    // Special results arrive here with valid still low; raise it one edge later
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign OUT         = out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - directed self-checking bench for fp_div (MANTISSA=8)
module tb_fp_div;

    localparam int M = 8;
    localparam int W = M + 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready, out_valid, div_by_zero;
    logic [W-1:0] OUT;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fp_div #(.MANTISSA(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .OUT        (OUT),
        .div_by_zero(div_by_zero)
    );

    // lat = edges after the accept edge until out_valid is seen (capped at 40)
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] o, output logic d, output int lat);
        issue(a, b, lat);
        o = OUT;
        d = div_by_zero;
        consume();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (OUT !== 17'h00000) begin tests_failed++; $display("FAIL reset_OUT: got %h expected 00000", OUT); end
        tests_run++;
        if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic;
        logic [W-1:0] o;
        logic d;
        int lat;
        run_op(17'h08180, 17'h08080, o, d, lat);
        tests_run++;
        if (o !== 17'h08000) begin tests_failed++; $display("FAIL basic_OUT: got %h expected 08000", o); end
        tests_run++;
        if (d !== 1'b0) begin tests_failed++; $display("FAIL basic_dbz: got %b expected 0", d); end
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 11", lat); end
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] o;
        logic d;
        int lat;
        run_op(17'h07F00, 17'h08080, o, d, lat);
        tests_run++;
        if (o !== 17'h07D55) begin tests_failed++; $display("FAIL norm_one_third_OUT: got %h expected 07D55", o); end
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL norm_one_third_latency: got %0d expected 11", lat); end
        run_op(17'h18180, 17'h08000, o, d, lat);
        tests_run++;
        if (o !== 17'h18080) begin tests_failed++; $display("FAIL neg_six_half_OUT: got %h expected 18080", o); end
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL neg_six_half_latency: got %0d expected 11", lat); end
    endtask

    task automatic test_specials;
        logic [W-1:0] va [4] = '{17'h07F00, 17'h00000, 17'h0FF00, 17'h07F00};
        logic [W-1:0] vb [4] = '{17'h00000, 17'h00000, 17'h0FF00, 17'h0FF00};
        logic [W-1:0] vo [4] = '{17'h0FF00, 17'h1FF80, 17'h1FF80, 17'h00000};
        logic         vd [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] o;
        logic d;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], o, d, lat);
            tests_run++;
            if (o !== vo[i]) begin tests_failed++; $display("FAIL special%0d_OUT: got %h expected %h", i, o, vo[i]); end
            tests_run++;
            if (d !== vd[i]) begin tests_failed++; $display("FAIL special%0d_dbz: got %b expected %b", i, d, vd[i]); end
            tests_run++;
            if (lat !== 1) begin tests_failed++; $display("FAIL special%0d_latency: got %0d expected 1", i, lat); end
        end
    endtask

    task automatic test_range;
        logic [W-1:0] va [2] = '{17'h00100, 17'h0FE00};
        logic [W-1:0] vb [2] = '{17'h08000, 17'h07E00};
        logic [W-1:0] vo [2] = '{17'h00000, 17'h0FF00};
        logic [W-1:0] o;
        logic d;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], o, d, lat);
            tests_run++;
            if (o !== vo[i]) begin tests_failed++; $display("FAIL range%0d_OUT: got %h expected %h", i, o, vo[i]); end
            tests_run++;
            if (d !== 1'b0) begin tests_failed++; $display("FAIL range%0d_dbz: got %b expected 0", i, d); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int stray;
        issue(17'h08180, 17'h08080, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 17'h07F00;
            B = 17'h0FF00;
            in_valid = (i % 2 == 0);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || OUT !== 17'h08000 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got valid=%b OUT=%h in_ready=%b expected 1/08000/0",
                         i, out_valid, OUT, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        stray = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
        end
        tests_run++;
        if (stray !== 0) begin tests_failed++; $display("FAIL backpressure_ignored_in_valid: got %0d busy cycles expected 0", stray); end
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] o;
        logic d;
        int lat;
        int seen;
        @(negedge clk);
        A = 17'h08180;
        B = 17'h08080;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); end
        run_op(17'h08180, 17'h08080, o, d, lat);
        tests_run++;
        if (o !== 17'h08000) begin tests_failed++; $display("FAIL abort_rerun_OUT: got %h expected 08000", o); end
        tests_run++;
        if (lat !== 11) begin tests_failed++; $display("FAIL abort_rerun_latency: got %0d expected 11", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
